// File: rtl/cvm300_frame_source.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cvm300_frame_source
//
// Sensor-side pattern transmitter for the CVM300 pixel interface. A rising edge
// on frame_req starts one frame: a frame-overhead interval, then ROWS lines of
// COLS pixels separated by HBLANK idle cycles. It stands in for the sensor
// during bring-up and shares the CVM_clk domain with the capture path.
//
// Ports
//   CVM_clk      in   1   sole clock, rising edge
//   reset        in   1   asynchronous active-high, clears every register
//   sys_res_n    in   1   synchronous active-low soft reset
//   frame_req    in   1   frame request, rising edge starts a frame
//   pattern_sel  in   2   0 col ramp, 1 row+col+frame ramp, 2 checker, 3 0x2AA
//   Line_valid   out  1   high for the COLS pixels of each line
//   Data_valid   out  1   identical to Line_valid
//   D            out  10  pixel value, 0 whenever Data_valid is low
//   frame_busy   out  1   high while the sequencer is not idle
//   frame_count  out  16  completed frames, wraps
//   req_dropped  out  1   sticky: request seen while another was pending
// -----------------------------------------------------------------------------
module cvm300_frame_source #(
   parameter int ROWS       = 488,
   parameter int COLS       = 648,
   parameter int HBLANK     = 8,
   parameter int FOT_CYCLES = 16
) (
   input  logic        CVM_clk,
   input  logic        reset,
   input  logic        sys_res_n,
   input  logic        frame_req,
   input  logic [1:0]  pattern_sel,
   output logic        Line_valid,
   output logic        Data_valid,
   output logic [9:0]  D,
   output logic        frame_busy,
   output logic [15:0] frame_count,
   output logic        req_dropped
);

   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int CNT_MAX = (FOT_CYCLES > HBLANK) ? FOT_CYCLES : HBLANK;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [CNT_W-1:0] FOT_LAST = CNT_W'(FOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HBLANK - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FOT,
      S_LINE,
      S_HBLANK
   } state_t;

   state_t             state_q;
   logic               req_q;
   logic               pending_q;
   logic               dropped_q;
   logic [1:0]         pat_q;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [15:0]        fcount_q;
   logic               lv_q;
   logic [9:0]         d_q;
   logic               busy_q;
   logic               req_edge_d;

   assign req_edge_d = frame_req & ~req_q;

   // Pixel value for the latched pattern; all sums are truncated to 10 bits.
   function automatic logic [9:0] pixel(input logic [1:0]       sel,
                                        input logic [ROW_W-1:0] r,
                                        input logic [COL_W-1:0] c,
                                        input logic [9:0]       fc);
      logic [9:0] r10;
      logic [9:0] c10;
      logic [9:0] sum;
      r10 = 10'(r);
      c10 = 10'(c);
      sum = r10 + c10 + fc;
      case (sel)
         2'd0:    pixel = c10;
         2'd1:    pixel = sum;
         2'd2:    pixel = (r10[0] ^ c10[0]) ? 10'h3FF : 10'h000;
         default: pixel = 10'h2AA;
      endcase
   endfunction

   // Outputs are registered and lag the state by one cycle: a LINE cycle
   // presents its pixel on the edge that ends it, so the first pixel lands
   // FOT_CYCLES+1 edges after the request edge.
   always_ff @(posedge CVM_clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         pending_q <= 1'b0;
         dropped_q <= 1'b0;
         pat_q     <= 2'd0;
         row_q     <= '0;
         col_q     <= '0;
         cnt_q     <= '0;
         fcount_q  <= 16'd0;
         lv_q      <= 1'b0;
         d_q       <= 10'd0;
         busy_q    <= 1'b0;
      end else begin
         req_q <= frame_req;
         if (!sys_res_n) begin
            // Soft reset: any edge seen in this cycle is discarded.
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            fcount_q  <= 16'd0;
            lv_q      <= 1'b0;
            d_q       <= 10'd0;
            busy_q    <= 1'b0;
         end else begin
            lv_q <= 1'b0;
            d_q  <= 10'd0;

            // One request may queue behind the running frame; a second is lost.
            if (state_q != S_IDLE && req_edge_d) begin
               if (pending_q) dropped_q <= 1'b1;
               else           pending_q <= 1'b1;
            end

            case (state_q)
               S_IDLE: begin
                  if (req_edge_d) begin
                     state_q <= S_FOT;
                     pat_q   <= pattern_sel;
                     row_q   <= '0;
                     col_q   <= '0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end

               S_FOT: begin
                  if (cnt_q == FOT_LAST) begin
                     state_q <= S_LINE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               S_LINE: begin
                  lv_q <= 1'b1;
                  d_q  <= pixel(pat_q, row_q, col_q, fcount_q[9:0]);
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     cnt_q <= '0;
                     if (row_q != ROW_LAST) begin
                        state_q <= S_HBLANK;
                        row_q   <= row_q + 1'b1;
                     end else begin
                        fcount_q <= fcount_q + 16'd1;
                        row_q    <= '0;
                        // A request arriving on the frame-done edge itself
                        // chains straight into the next frame as well.
                        if (pending_q || req_edge_d) begin
                           state_q   <= S_FOT;
                           pat_q     <= pattern_sel;
                           pending_q <= 1'b0;
                        end else begin
                           state_q <= S_IDLE;
                           busy_q  <= 1'b0;
                        end
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end

               S_HBLANK: begin
                  if (cnt_q == HB_LAST) begin
                     state_q <= S_LINE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Line_valid  = lv_q;
   assign Data_valid  = lv_q;
   assign D           = d_q;
   assign frame_busy  = busy_q;
   assign frame_count = fcount_q;
   assign req_dropped = dropped_q;

endmodule

// File: tb/tb_cvm300_frame_source.sv
`timescale 1ns/1ps
module tb_cvm300_frame_source;

   localparam int ROWS = 4;
   localparam int COLS = 8;
   localparam int HB   = 2;
   localparam int FOT  = 3;
   localparam int ROWS_B = 2;
   localparam int COLS_B = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sys_res_n;
   logic        req_a;
   logic        req_b;
   logic [1:0]  sel_a;
   logic [1:0]  sel_b;

   logic        lv_a, dv_a, busy_a, drop_a;
   logic [9:0]  d_a;
   logic [15:0] fc_a;
   logic        lv_b, dv_b, busy_b, drop_b;
   logic [9:0]  d_b;
   logic [15:0] fc_b;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_a[$];
   logic [9:0] exp_b[$];

   cvm300_frame_source #(.ROWS(ROWS), .COLS(COLS), .HBLANK(HB), .FOT_CYCLES(FOT)) dut_a (
      .CVM_clk(clk), .reset(rst), .sys_res_n(sys_res_n), .frame_req(req_a),
      .pattern_sel(sel_a), .Line_valid(lv_a), .Data_valid(dv_a), .D(d_a),
      .frame_busy(busy_a), .frame_count(fc_a), .req_dropped(drop_a));

   cvm300_frame_source #(.ROWS(ROWS_B), .COLS(COLS_B), .HBLANK(HB), .FOT_CYCLES(FOT)) dut_b (
      .CVM_clk(clk), .reset(rst), .sys_res_n(sys_res_n), .frame_req(req_b),
      .pattern_sel(sel_b), .Line_valid(lv_b), .Data_valid(dv_b), .D(d_b),
      .frame_busy(busy_b), .frame_count(fc_b), .req_dropped(drop_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [9:0] model_pix(input int sel, input int r, input int c, input int fc);
      int s;
      s = r + c + fc;
      case (sel)
         0:       return c[9:0];
         1:       return s[9:0];
         2:       return ((r % 2) != (c % 2)) ? 10'h3FF : 10'h000;
         default: return 10'h2AA;
      endcase
   endfunction

   task automatic push_frame_a(input int sel, input int fc);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_a.push_back(model_pix(sel, r, c, fc));
   endtask

   task automatic push_frame_b(input int sel, input int fc);
      for (int r = 0; r < ROWS_B; r++)
         for (int c = 0; c < COLS_B; c++)
            exp_b.push_back(model_pix(sel, r, c, fc));
   endtask

   // Stimulus acts 2 ns after the edge, monitors sample 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard monitors: pop one expected pixel per Data_valid cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("lv_eq_dv_a", lv_a, dv_a);
         if (dv_a) begin
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pix_a: unexpected pixel %0d, none required", d_a);
            end else begin
               check("pix_a", d_a, exp_a.pop_front());
            end
         end else begin
            check("idle_d_a", d_a, 0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("lv_eq_dv_b", lv_b, dv_b);
         if (dv_b) begin
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pix_b: unexpected pixel %0d, none required", d_b);
            end else begin
               check("pix_b", d_b, exp_b.pop_front());
            end
         end else begin
            check("idle_d_b", d_b, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   // One complete frame on instance A with latency and shape checks.
   task automatic run_frame_a(input logic [1:0] sel, input int fc);
      int n, t, last, ones, rises;
      logic prev;
      push_frame_a(int'(sel), fc);
      sel_a = sel;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      sel_a = sel ^ 2'b11;
      n = 0;
      while (!dv_a && n < 50) begin
         tick();
         n++;
      end
      check("first_dv_latency", n, FOT + 1);
      t = 0;
      last = 0;
      ones = dv_a ? 1 : 0;
      rises = ones;
      prev = dv_a;
      while (busy_a && t < 500) begin
         tick();
         t++;
         if (dv_a) begin
            ones++;
            last = t;
            if (!prev) rises++;
         end
         prev = dv_a;
      end
      check("busy_low_at_end", busy_a, 0);
      check("dv_cycles", ones, ROWS * COLS);
      check("line_bursts", rises, ROWS);
      check("frame_span", last + 1, ROWS * COLS + (ROWS - 1) * HB);
      check("frame_count", fc_a, (fc + 1) & 16'hFFFF);
      check("queue_drained_a", exp_a.size(), 0);
   endtask

   initial begin
      int t, g, bz;
      rst = 1'b1;
      sys_res_n = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      sel_a = 2'd0;
      sel_b = 2'd1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_lv", lv_a, 0);
      check("rst_dv", dv_a, 0);
      check("rst_d", d_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_fc", fc_a, 0);
      check("rst_drop", drop_a, 0);

      // Frame timing, column ramp, then the other patterns.
      run_frame_a(2'd0, 0);
      run_frame_a(2'd1, 1);
      run_frame_a(2'd1, 2);
      run_frame_a(2'd2, 3);
      run_frame_a(2'd3, 4);
      repeat (3) tick();

      // Soft reset mid-line with a pending request and a coincident edge.
      push_frame_a(0, 5);
      sel_a = 2'd0;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      t = 0;
      while (!dv_a && t < 50) begin
         tick();
         t++;
      end
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      tick();
      sys_res_n = 1'b0;
      req_a = 1'b1;
      tick();
      sys_res_n = 1'b1;
      check("sres_dv", dv_a, 0);
      check("sres_busy", busy_a, 0);
      check("sres_fc", fc_a, 0);
      check("sres_drop", drop_a, 0);
      exp_a.delete();
      tick();
      req_a = 1'b0;
      bz = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy_a) bz++;
      end
      check("sres_edge_ignored", bz, 0);
      run_frame_a(2'd0, 0);
      repeat (10) tick();
      check("sres_pending_cleared", busy_a, 0);
      check("sres_single_frame", fc_a, 1);

      // Asynchronous reset between clock edges in the middle of a line.
      push_frame_a(0, 1);
      sel_a = 2'd0;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      t = 0;
      while (!dv_a && t < 50) begin
         tick();
         t++;
      end
      tick();
      #1;
      rst = 1'b1;
      #1;
      check("arst_lv", lv_a, 0);
      check("arst_dv", dv_a, 0);
      check("arst_d", d_a, 0);
      check("arst_busy", busy_a, 0);
      check("arst_fc", fc_a, 0);
      exp_a.delete();
      tick();
      tick();
      rst = 1'b0;
      bz = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy_a || dv_a) bz++;
      end
      check("arst_no_frame", bz, 0);

      // Chained request and a dropped third request.
      push_frame_a(0, 0);
      sel_a = 2'd0;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      repeat (10) tick();
      push_frame_a(2, 1);
      sel_a = 2'd2;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      tick();
      check("drop_after_second", drop_a, 0);
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      tick();
      check("drop_after_third", drop_a, 1);
      t = 0;
      while (fc_a == 16'd0 && t < 200) begin
         tick();
         t++;
      end
      check("chain_first_done", fc_a, 1);
      check("chain_last_pixel", dv_a, 1);
      check("chain_busy_at_done", busy_a, 1);
      g = 0;
      bz = 0;
      tick();
      while (!dv_a && g < 50) begin
         g++;
         if (!busy_a) bz++;
         tick();
      end
      check("chain_gap", g, FOT);
      check("chain_no_idle", bz, 0);
      t = 0;
      while (busy_a && t < 200) begin
         tick();
         t++;
      end
      check("chain_busy_end", busy_a, 0);
      check("chain_final_count", fc_a, 2);
      check("chain_drop_sticky", drop_a, 1);
      check("queue_drained_chain", exp_a.size(), 0);

      // Wide instance: row+col+frame ramp wrapping through 0x3FF.
      push_frame_b(1, 0);
      push_frame_b(1, 1);
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      tick();
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      t = 0;
      while (busy_b && t < 6000) begin
         tick();
         t++;
      end
      check("b_busy_end", busy_b, 0);
      check("b_frame_count", fc_b, 2);
      check("b_drop", drop_b, 0);
      check("queue_drained_b", exp_b.size(), 0);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
